// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS-subset datapath: sequences PC, IR,
// register file, ALU muxes and memory strobes, with memory wait, retire count and illegal-op flag.
module multicycle_control #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       opcode,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             PC_en,
   output logic [1:0]       pc_src,
   output logic             IorD,
   output logic             branch,
   output logic             ir_write,
   output logic             mem_write,
   output logic             reg_write,
   output logic             reg_dst,
   output logic             mem_to_reg,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic [3:0]       state,
   output logic             illegal_op,
   output logic [CNT_W-1:0] retired
);

   // state  | meaning
   // FETCH  | read instruction at PC, PC += 4, wait on mem_ready
   // DECODE | register read, branch target into alu_out, dispatch on opcode
   // MEMADR | compute load/store address
   // MEMRD  | load data read, wait on mem_ready
   // MEMWB  | write loaded data to rt
   // MEMWR  | store data write, wait on mem_ready
   // EXEC   | R-type ALU operation
   // ALUWB  | write ALU result to rd
   // BRANCH | beq compare, PC <- target when zero
   // ADDIEX | addi ALU operation
   // ADDIWB | write addi result to rt
   // JUMP   | PC <- jump target
   localparam logic [3:0] S_FETCH  = 4'd0;
   localparam logic [3:0] S_DECODE = 4'd1;
   localparam logic [3:0] S_MEMADR = 4'd2;
   localparam logic [3:0] S_MEMRD  = 4'd3;
   localparam logic [3:0] S_MEMWB  = 4'd4;
   localparam logic [3:0] S_MEMWR  = 4'd5;
   localparam logic [3:0] S_EXEC   = 4'd6;
   localparam logic [3:0] S_ALUWB  = 4'd7;
   localparam logic [3:0] S_BRANCH = 4'd8;
   localparam logic [3:0] S_ADDIEX = 4'd9;
   localparam logic [3:0] S_ADDIWB = 4'd10;
   localparam logic [3:0] S_JUMP   = 4'd11;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   logic [3:0]       state_q, state_d;
   logic             illegal_q, illegal_d;
   logic             is_sw_q, is_sw_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic             retire;

   logic             pc_write_c, branch_c, ir_write_c, mem_write_c, reg_write_c;
   logic             iord_c, reg_dst_c, mem_to_reg_c, alu_src_a_c;
   logic [1:0]       pc_src_c, alu_src_b_c, alu_op_c;

   always_comb begin
      state_d   = state_q;
      illegal_d = illegal_q;
      is_sw_d   = is_sw_q;
      retire    = 1'b0;
      case (state_q)
         S_FETCH:  if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            // load/store flavour is latched here so MEMADR does not depend on opcode later
            is_sw_d = (opcode == OP_SW);
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXEC;
               OP_BEQ:       state_d = S_BRANCH;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JUMP;
               default: begin
                  state_d   = S_FETCH;
                  illegal_d = 1'b1;
               end
            endcase
         end
         S_MEMADR: state_d = is_sw_q ? S_MEMWR : S_MEMRD;
         S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
         S_MEMWB: begin
            state_d = S_FETCH;
            retire  = 1'b1;
         end
         S_MEMWR: if (mem_ready) begin
            state_d = S_FETCH;
            retire  = 1'b1;
         end
         S_EXEC:   state_d = S_ALUWB;
         S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: begin
            state_d = S_FETCH;
            retire  = 1'b1;
         end
         S_ADDIEX: state_d = S_ADDIWB;
         default:  state_d = S_FETCH;
      endcase
      retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= S_FETCH;
         illegal_q <= 1'b0;
         is_sw_q   <= 1'b0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
         is_sw_q   <= is_sw_d;
         retired_q <= retired_d;
      end
   end

   always_comb begin
      pc_write_c   = 1'b0;
      branch_c     = 1'b0;
      ir_write_c   = 1'b0;
      mem_write_c  = 1'b0;
      reg_write_c  = 1'b0;
      iord_c       = 1'b0;
      reg_dst_c    = 1'b0;
      mem_to_reg_c = 1'b0;
      alu_src_a_c  = 1'b0;
      pc_src_c     = 2'b00;
      alu_src_b_c  = 2'b00;
      alu_op_c     = 2'b00;
      case (state_q)
         S_FETCH: begin
            alu_src_b_c = 2'b01;
            ir_write_c  = mem_ready;
            pc_write_c  = mem_ready;
         end
         S_DECODE: alu_src_b_c = 2'b11;
         S_MEMADR: begin
            alu_src_a_c = 1'b1;
            alu_src_b_c = 2'b10;
         end
         S_MEMRD: iord_c = 1'b1;
         S_MEMWB: begin
            mem_to_reg_c = 1'b1;
            reg_write_c  = 1'b1;
         end
         S_MEMWR: begin
            iord_c      = 1'b1;
            mem_write_c = 1'b1;
         end
         S_EXEC: begin
            alu_src_a_c = 1'b1;
            alu_op_c    = 2'b10;
         end
         S_ALUWB: begin
            reg_dst_c   = 1'b1;
            reg_write_c = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a_c = 1'b1;
            alu_op_c    = 2'b01;
            branch_c    = 1'b1;
            pc_src_c    = 2'b01;
         end
         S_ADDIEX: begin
            alu_src_a_c = 1'b1;
            alu_src_b_c = 2'b10;
         end
         S_ADDIWB: reg_write_c = 1'b1;
         S_JUMP: begin
            pc_src_c   = 2'b10;
            pc_write_c = 1'b1;
         end
         default: ;
      endcase
   end

   // every output is held low while reset is asserted, before the first reset edge too
   always_comb begin
      PC_en      = rst & (pc_write_c | (branch_c & zero));
      branch     = rst & branch_c;
      ir_write   = rst & ir_write_c;
      mem_write  = rst & mem_write_c;
      reg_write  = rst & reg_write_c;
      IorD       = rst & iord_c;
      reg_dst    = rst & reg_dst_c;
      mem_to_reg = rst & mem_to_reg_c;
      alu_src_a  = rst & alu_src_a_c;
      pc_src     = rst ? pc_src_c    : 2'b00;
      alu_src_b  = rst ? alu_src_b_c : 2'b00;
      alu_op     = rst ? alu_op_c    : 2'b00;
      state      = rst ? state_q     : 4'd0;
      illegal_op = rst & illegal_q;
      retired    = rst ? retired_q   : '0;
   end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multicycle MIPS-subset datapath.
- Sequences the program counter/address unit (PC_en, pc_src, IorD), instruction register, register file, ALU operand muxes and memory strobes across the fetch/decode/execute/memory/writeback steps.
- Supports a memory wait handshake, a retired-instruction counter and a sticky illegal-opcode flag.

Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-low (0 = reset)
- opcode  in  6  instr[31:26] from the instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- PC_en  out  1  PC load enable, = pc_write | (branch & zero)
- pc_src  out  2  00 alu_result, 01 alu_out, 10 sign_extend_jump
- IorD  out  1  0 = address from PC, 1 = address from alu_out
- branch  out  1  conditional PC write request
- ir_write  out  1  instruction register load
- mem_write  out  1  memory write strobe
- reg_write  out  1  register file write
- reg_dst  out  1  0 = rt, 1 = rd
- mem_to_reg  out  1  0 = alu_out, 1 = memory data
- alu_src_a  out  1  0 = PC, 1 = register A
- alu_src_b  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- alu_op  out  2  00 add, 01 sub, 10 funct-decoded
- state  out  4  current state encoding (debug)
- illegal_op  out  1  sticky, set on undefined opcode
- retired  out  CNT_W  count of completed instructions

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12-15 are unreachable; if entered, go to FETCH.
- Reset (rst=0 at a clk edge): state=FETCH, illegal_op=0, retired=0.
- While rst=0, all write/enable outputs (PC_en, ir_write, mem_write, reg_write, branch) are forced to 0. All other outputs are 0 during reset.
- Control outputs are decoded combinationally from state (Moore), except where noted. Unlisted outputs are 0.
- FETCH:
  - IorD=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - ir_write=PC_en=mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next state by opcode:
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000000 (R-type) -> EXEC
  - 000100 (beq) -> BRANCH
  - 001000 (addi) -> ADDIEX
  - 000010 (j) -> JUMP
  - any other opcode -> FETCH, set illegal_op=1; retired does not increment.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Go to MEMRD if lw, MEMWR if sw.
- MEMRD: IorD=1. Stay while mem_ready=0; go to MEMWB when mem_ready=1.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1. Go to FETCH.
- MEMWR: IorD=1, mem_write=1. Hold mem_write while mem_ready=0; go to FETCH when mem_ready=1.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Go to ALUWB.
- ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1. Go to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, branch=1, pc_src=01. PC_en=zero. Go to FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. Go to ADDIWB.
- ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1. Go to FETCH.
- JUMP: pc_src=10, PC_en=1. Go to FETCH.
- retired increments by 1 on each transition into FETCH from MEMWB, MEMWR (with mem_ready=1), ALUWB, BRANCH, ADDIWB or JUMP. It wraps from 2^CNT_W-1 to 0.
- illegal_op stays set until reset; the FSM keeps running after it is set.
- PC_en never asserts in any state other than FETCH, BRANCH and JUMP.
- Reset asserted mid-instruction (any state, including mem_ready waits): next state is FETCH, no strobe fires in the reset cycle, counter and flag are cleared.
- mem_ready is ignored outside FETCH, MEMRD and MEMWR.

Test Plan:
- Release reset with mem_ready=1 and opcode=000000 -> state sequence 0,1,6,7,0. PC_en=1 only in FETCH. reg_write=1 and reg_dst=1 in ALUWB. retired=1.
- lw (100011) with mem_ready held 0 for 3 cycles in MEMRD -> state stays 3 for 3 cycles, IorD=1 throughout. MEMWB follows with mem_to_reg=1. 5 states + 3 waits = 8 cycles total.
- beq (000100): zero=1 -> PC_en=1, pc_src=01 in BRANCH. Repeat with zero=0 -> PC_en=0. retired increments in both cases.
- j (000010) -> JUMP asserts PC_en=1 with pc_src=10. Then addi (001000) -> ADDIEX alu_src_b=10, ADDIWB reg_dst=0. After both, retired=2.
- opcode=111111 in DECODE -> illegal_op=1, next state FETCH, retired unchanged. The following valid instruction completes with illegal_op still 1.
- Assert rst=0 while in MEMWR with mem_ready=0 -> mem_write=0 that cycle, state=0, retired=0, illegal_op=0.
- Counter wrap with CNT_W=4: 16 R-type instructions -> retired returns to 0.
